communicate_rx: RTL

Serial receiver for the single-wire word link. It samples `datain` while `comEn` is high, reassembles one 32-bit word MSB first, and presents the word on a valid/ready holding register for downstream logic. It also flags short frames, long frames and overruns. It sits opposite the word transmitter, in the same clock domain, with no synchroniser on the link inputs.

---
 rtl/communicate_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/communicate_rx.sv
// communicate_rx
//
// Serial receiver for the single-wire word link. While comEn is high the
// receiver takes one lead-in sample and then shifts in WIDTH data bits, MSB
// first. The completed word is presented on a valid/ready holding register.
// Short frames, long frames and dropped words are flagged.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   datain     in   serial data, MSB first
//   comEn      in   frame enable from the transmitter
//   rx_ready   in   downstream accepts rx_word when rx_valid && rx_ready
//   rx_word    out  last delivered word
//   rx_valid   out  holding register full
//   short_err  out  one-cycle pulse, comEn fell before WIDTH data bits
//   long_err   out  one-cycle pulse, comEn still high after WIDTH data bits
//   overrun    out  sticky, a completed word was dropped (cleared by reset)
//
// State  | meaning
// IDLE   | waiting for comEn; the first high sample is the lead-in
// SHIFT  | shifting data bits, counter holds the index of the current bit
// TAIL   | word complete; expecting comEn low
// DRAIN  | over-long frame; ignore the link until comEn falls

module communicate_rx #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             datain,
    input  logic             comEn,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_word,
    output logic             rx_valid,
    output logic             short_err,
    output logic             long_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             ovr_q, ovr_d;

    logic             complete;
    logic             accept;
    logic [WIDTH-1:0] next_word;

    assign next_word = {shift_q[WIDTH-2:0], datain};
    assign accept    = valid_q && rx_ready;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                if (comEn) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (comEn) begin
                    shift_d = next_word;
                    if (cnt_q == CNT_LAST) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = TAIL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    short_d = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            TAIL: begin
                if (comEn) begin
                    long_d  = 1'b1;
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!comEn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: a completion may reuse the slot being consumed in
    // the same cycle; otherwise a full slot forces the new word to be dropped.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (complete) begin
            if (!valid_q || accept) begin
                word_d  = next_word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            short_q <= short_d;
            long_q  <= long_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_word   = word_q;
    assign rx_valid  = valid_q;
    assign short_err = short_q;
    assign long_err  = long_q;
    assign overrun   = ovr_q;

endmodule
